// File: rtl/cache_pkg.sv
// Shared cache constants and the fill-engine state encoding, reused by the
// cache RAM and the read-side tag logic.
package cache_pkg;

    localparam int LINE_WORDS    = 32;
    localparam int OFFSET_BITS   = 5;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_SEL_BITS = 2;

    localparam logic [OFFSET_BITS-1:0] LAST_OFFSET = OFFSET_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_FETCH = 2'd1,
        FILL_FLUSH = 2'd2,
        FILL_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// External SRAM read handshake plus cache RAM bank write port, as seen by the
// line-fill engine (master) and by the SRAM/RAM side (slave).
interface cache_fill_ctrl_if
    import cache_pkg::*;
#(
    parameter int data_width       = 8,
    parameter int ext_address_bits = 19
);

    logic                        sram_rd_o;
    logic [ext_address_bits-1:0] sram_addr_o;
    logic [data_width-1:0]       sram_data_i;
    logic                        sram_ack_i;

    logic [BANK_SEL_BITS-1:0]    bank_select_o;
    logic                        bank_enable_o;
    logic [OFFSET_BITS-1:0]      write_address_o;
    logic [data_width-1:0]       write_data_o;

    modport master (
        output sram_rd_o, sram_addr_o,
        input  sram_data_i, sram_ack_i,
        output bank_select_o, bank_enable_o, write_address_o, write_data_o
    );

    modport slave (
        input  sram_rd_o, sram_addr_o,
        output sram_data_i, sram_ack_i,
        input  bank_select_o, bank_enable_o, write_address_o, write_data_o
    );

endinterface

// File: rtl/cache_fill_ctrl.sv
// Line-fill engine: fetches one 32-word line from external SRAM and writes it
// into the selected cache bank, tracking per-bank line validity.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int data_width       = 8,
    parameter int ext_address_bits = 19
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  fill_req_i,
    input  logic [ext_address_bits-OFFSET_BITS-1:0] fill_line_i,
    input  logic [BANK_SEL_BITS-1:0]              fill_bank_i,
    output logic                                  fill_ready_o,
    output logic                                  fill_done_o,
    output logic [NUM_BANKS-1:0]                  bank_valid_o,
    cache_fill_ctrl_if.master                     bus
);

    localparam int LINE_BITS = ext_address_bits - OFFSET_BITS;

    fill_state_e              state_q, state_d;
    logic                     sram_rd;
    logic                     accept, beat;

    logic [LINE_BITS-1:0]     line_q;
    logic [OFFSET_BITS-1:0]   offset_q;
    logic [BANK_SEL_BITS-1:0] bank_q;
    logic                     pending_q;
    logic [OFFSET_BITS-1:0]   waddr_q;
    logic [data_width-1:0]    wdata_q;
    logic [NUM_BANKS-1:0]     valid_q;

    assign accept = fill_req_i & fill_ready_o;
    assign beat   = sram_rd & bus.sram_ack_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= FILL_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        fill_ready_o = 1'b0;
        fill_done_o  = 1'b0;
        sram_rd      = 1'b0;
        unique case (state_q)
            FILL_IDLE: begin
                fill_ready_o = 1'b1;
                if (fill_req_i) state_d = FILL_FETCH;
            end
            FILL_FETCH: begin
                sram_rd = 1'b1;
                if (bus.sram_ack_i && offset_q == LAST_OFFSET) state_d = FILL_FLUSH;
            end
            FILL_FLUSH: state_d = FILL_DONE;
            FILL_DONE: begin
                fill_done_o = 1'b1;
                state_d     = FILL_IDLE;
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            line_q    <= '0;
            offset_q  <= '0;
            bank_q    <= '0;
            pending_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            valid_q   <= '0;
        end else begin
            pending_q <= beat;
            if (accept) begin
                line_q               <= fill_line_i;
                bank_q               <= fill_bank_i;
                offset_q             <= '0;
                valid_q[fill_bank_i] <= 1'b0;
            end
            if (beat) begin
                waddr_q <= offset_q;
                wdata_q <= bus.sram_data_i;
                if (offset_q != LAST_OFFSET) offset_q <= offset_q + 1'b1;
            end
            // Set on the FLUSH->DONE edge so the flag rises together with fill_done_o.
            if (state_q == FILL_FLUSH) valid_q[bank_q] <= 1'b1;
        end
    end

    assign bus.sram_rd_o       = sram_rd;
    assign bus.sram_addr_o     = {line_q, offset_q};
    assign bus.bank_select_o   = bank_q;
    assign bus.bank_enable_o   = pending_q;
    assign bus.write_address_o = waddr_q;
    assign bus.write_data_o    = wdata_q;
    assign bank_valid_o        = valid_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: SRAM returns addr[7:0]^0xA5, every cycle
// of each fill is compared against hand-derived timing.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        fill_req = 1'b0;
    logic [13:0] fill_line = '0;
    logic [1:0]  fill_bank = '0;
    logic        ack = 1'b0;
    logic        fill_ready_o, fill_done_o;
    logic [3:0]  bank_valid_o;
    logic [3:0]  exp_valid = 4'b0000;

    int tests = 0;
    int fails = 0;

    cache_fill_ctrl_if #(.data_width(8), .ext_address_bits(19)) bus ();

    cache_fill_ctrl #(.data_width(8), .ext_address_bits(19)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .fill_req_i   (fill_req),
        .fill_line_i  (fill_line),
        .fill_bank_i  (fill_bank),
        .fill_ready_o (fill_ready_o),
        .fill_done_o  (fill_done_o),
        .bank_valid_o (bank_valid_o),
        .bus          (bus)
    );

    assign bus.sram_ack_i  = ack;
    assign bus.sram_data_i = bus.sram_addr_o[7:0] ^ 8'hA5;

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_word(input logic [13:0] line, input logic [4:0] off);
        return {line[2:0], off} ^ 8'hA5;
    endfunction

    task automatic check_reset();
        check("rst_ready", fill_ready_o, 1);
        check("rst_done", fill_done_o, 0);
        check("rst_rd", bus.sram_rd_o, 0);
        check("rst_addr", bus.sram_addr_o, 0);
        check("rst_en", bus.bank_enable_o, 0);
        check("rst_sel", bus.bank_select_o, 0);
        check("rst_waddr", bus.write_address_o, 0);
        check("rst_wdata", bus.write_data_o, 0);
        check("rst_valid", bank_valid_o, 0);
    endtask

    // One fill. ack on cycles where cyc%period==0; optional busy request pulse
    // at busy_cycle; optional reset once abort_beat beats have completed.
    task automatic do_fill(input logic [13:0] line, input logic [1:0] bank, input int period,
                           input int busy_cycle, input int abort_beat);
        int          beats;
        int          cyc;
        logic        prev_beat;
        logic [4:0]  prev_off;
        logic        ackv;
        @(negedge clk_i);
        check("ready_idle", fill_ready_o, 1);
        fill_req  = 1'b1;
        fill_line = line;
        fill_bank = bank;
        ack       = 1'b0;
        @(negedge clk_i);
        fill_req  = 1'b0;
        fill_line = ~line;
        fill_bank = ~bank;
        exp_valid[bank] = 1'b0;
        check("valid_clr", bank_valid_o, exp_valid);
        beats = 0; cyc = 1; prev_beat = 1'b0; prev_off = '0;
        while (beats < 32 && cyc < 400) begin
            if (abort_beat > 0 && beats == abort_beat) begin
                reset_i = 1'b0;
                #1;
                check_reset();
                exp_valid = 4'b0000;
                @(negedge clk_i);
                reset_i = 1'b1;
                ack     = 1'b0;
                check("abort_valid", bank_valid_o, exp_valid);
                return;
            end
            check("fetch_rd", bus.sram_rd_o, 1);
            check("fetch_addr", bus.sram_addr_o, {line, beats[4:0]});
            check("fetch_ready", fill_ready_o, 0);
            check("fetch_done", fill_done_o, 0);
            check("fetch_en", bus.bank_enable_o, prev_beat);
            if (prev_beat) begin
                check("fetch_waddr", bus.write_address_o, prev_off);
                check("fetch_wdata", bus.write_data_o, exp_word(line, prev_off));
                check("fetch_sel", bus.bank_select_o, bank);
            end
            fill_req = (cyc == busy_cycle);
            if (cyc == busy_cycle) fill_bank = 2'd1;
            ackv      = ((cyc % period) == 0);
            ack       = ackv;
            prev_beat = ackv;
            prev_off  = beats[4:0];
            if (ackv) beats++;
            @(negedge clk_i);
            cyc++;
        end
        check("fill_beats", beats, 32);
        check("flush_cycle", cyc, 32 * period + 1);
        fill_req = 1'b0;
        ack      = 1'b1;
        check("flush_rd", bus.sram_rd_o, 0);
        check("flush_en", bus.bank_enable_o, 1);
        check("flush_waddr", bus.write_address_o, 31);
        check("flush_wdata", bus.write_data_o, exp_word(line, 5'd31));
        check("flush_sel", bus.bank_select_o, bank);
        check("flush_done", fill_done_o, 0);
        @(negedge clk_i);
        exp_valid[bank] = 1'b1;
        check("done_pulse", fill_done_o, 1);
        check("done_valid", bank_valid_o, exp_valid);
        check("done_en", bus.bank_enable_o, 0);
        check("done_ready", fill_ready_o, 0);
        @(negedge clk_i);
        check("idle_ready", fill_ready_o, 1);
        check("idle_done", fill_done_o, 0);
        check("idle_en", bus.bank_enable_o, 0);
        check("idle_rd", bus.sram_rd_o, 0);
        check("idle_addr", bus.sram_addr_o, {line, 5'd31});
        @(negedge clk_i);
        check("spur_en", bus.bank_enable_o, 0);
        check("spur_addr", bus.sram_addr_o, {line, 5'd31});
        check("spur_valid", bank_valid_o, exp_valid);
        ack = 1'b0;
    endtask

    initial begin
        #1;
        check_reset();
        #12;
        reset_i = 1'b1;

        do_fill(14'h0123, 2'd2, 1, 0, 0);
        check("zero_wait_valid", bank_valid_o, 4'b0100);

        do_fill(14'h0001, 2'd0, 3, 5, 0);
        check("busy_valid", bank_valid_o, 4'b0101);

        do_fill(14'h0200, 2'd3, 1, 0, 0);
        check("refill1_valid", bank_valid_o, 4'b1101);
        do_fill(14'h0201, 2'd3, 2, 0, 0);
        check("refill2_valid", bank_valid_o, 4'b1101);

        do_fill(14'h0456, 2'd2, 1, 0, 10);
        do_fill(14'h0456, 2'd2, 1, 0, 0);
        check("after_abort_valid", bank_valid_o, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Line-fill engine that sits directly upstream of the 4-bank cache RAM. On a fill request it reads one 32-word line from external SRAM over a request/acknowledge handshake and writes each word into the selected cache bank through the bank write port. It tracks per-bank line validity so read-side logic knows which banks hold complete lines.

## Interface
- data_width, 8, word width; equals the cache RAM data width
- ext_address_bits, 19, external SRAM word-address width; line address is ext_address_bits-5 bits
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  reset, asynchronous, active-low
- fill_req_i  in  1  fill request; accepted on an edge where fill_req_i & fill_ready_o
- fill_line_i  in  ext_address_bits-5  external line address, sampled at acceptance
- fill_bank_i  in  2  destination bank, sampled at acceptance
- fill_ready_o  out  1  high only in IDLE
- fill_done_o  out  1  one-cycle pulse when a line is fully written
- bank_valid_o  out  4  per-bank line-valid flags
- sram_rd_o  out  1  external read request, held until acknowledged
- sram_addr_o  out  ext_address_bits  {line, offset}; stable while sram_rd_o high
- sram_data_i  in  data_width  read data, valid when sram_ack_i high
- sram_ack_i  in  1  read acknowledge; completes a beat only when sram_rd_o is also high
- bank_select_o  out  2  drives cache RAM bank write select
- bank_enable_o  out  1  one-cycle write strobe to cache RAM
- write_address_o  out  5  word offset within the bank
- write_data_o  out  data_width  word to write

## Operation
- States: IDLE, FETCH, FLUSH, DONE.
- IDLE: fill_ready_o=1. On acceptance: latch line and bank, clear offset to 0, clear bank_valid_o[fill_bank_i], go to FETCH.
- FETCH: sram_rd_o=1, sram_addr_o={line, offset}. Edge with sram_ack_i=1 is a beat: capture sram_data_i and offset into the write registers, and set a write-pending flag. If offset≠31, increment offset and stay in FETCH. If offset=31, go to FLUSH.
- The write-pending flag makes bank_enable_o=1 for exactly the cycle after each beat. bank_select_o is the latched bank throughout the fill.
- FLUSH: sram_rd_o=0. The final word (offset 31) is written this cycle. Go to DONE.
- DONE: fill_done_o=1, set bank_valid_o[latched bank], go to IDLE.
- Offset is a 5-bit counter and never wraps within a fill; the end of the line is detected by offset==31 at a beat.
- fill_req_i while fill_ready_o=0 is ignored and not queued.
- sram_ack_i while sram_rd_o=0 is ignored.
- Refilling an already-valid bank clears its valid bit at acceptance. The other banks' bits are unaffected.

## Timing
- Reset, asynchronous and immediate: state IDLE, fill_ready_o=1, fill_done_o=0, sram_rd_o=0, sram_addr_o=0, bank_enable_o=0, bank_select_o=0, write_address_o=0, write_data_o=0, bank_valid_o=4'b0000.
- Reset mid-fill abandons the line. No further writes occur, the bank stays invalid, and the next request starts from offset 0.
- Cycle numbering: cycle 1 is the first cycle after the acceptance edge.
- With sram_ack_i held high:
  - sram_rd_o high in cycles 1–32.
  - Word k is written in cycle k+2.
  - FLUSH is cycle 33.
  - fill_done_o and the valid bit are set in cycle 34.
  - fill_ready_o=1 from cycle 35.
  - Fill occupancy is 34 cycles.
- Wait states stretch FETCH. Each write still follows its beat by exactly one cycle.
- Outputs are registered, except fill_ready_o, sram_rd_o and fill_done_o, which are decoded from state.

## Structure
- Shared package cache_pkg holds:
  - LINE_WORDS=32, OFFSET_BITS=5, NUM_BANKS=4, BANK_SEL_BITS=2
  - fill state encoding
- The cache RAM and any later read-side tag logic reuse these constants.
- Single module with no sub-module. FSM, offset counter and write registers are inline.

## Test plan
- Zero-wait fill:
  - Stimulus: line 0x0123, bank 2; model returns data = addr[7:0] ^ 0xA5 with ack always high.
  - Response: 32 writes to bank 2 at offsets 0..31 with matching data; done in cycle 34; bank_valid_o=4'b0100.
- Wait states:
  - Stimulus: ack asserted every 3rd cycle; line 0x0001, bank 0.
  - Response: each write exactly one cycle after its ack; sram_addr_o stable while waiting; done after the 32nd beat + 2 cycles.
- Request while busy:
  - Stimulus: second request (bank 1) pulsed during FETCH.
  - Response: ignored; only bank 0 written; bank_valid_o[1] stays 0.
- Reset mid-fill:
  - Stimulus: reset_i low after beat 10.
  - Response: all outputs at reset values immediately. A new fill to the same bank then completes all 32 words from offset 0.
- Refill of valid bank:
  - Stimulus: fill bank 3 twice.
  - Response: bank_valid_o[3] drops in cycle 1 of the second fill and returns high at its done; the other bits are unchanged.
- Spurious ack:
  - Stimulus: sram_ack_i high in IDLE and in FLUSH.
  - Response: no bank_enable_o, no offset change.
